// File: rtl/rx_control_module_pkg.sv
// rtl/rx_control_module_pkg.sv - shared baud constants and receiver state encoding
package rx_control_module_pkg;
  localparam int BPS_115200 = 434;
  localparam int BPS_9600   = 5208;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/rx_control_module_if.sv
// rtl/rx_control_module_if.sv - serial line, start-edge and received-byte signal bundle
interface rx_control_module_if;
  logic       h2l_sig;
  logic       rx_pin;
  logic       rx_en;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output h2l_sig, rx_pin, rx_en,
    input  rx_data, rx_done_sig, frame_err, rx_busy
  );

  modport slave (
    input  h2l_sig, rx_pin, rx_en,
    output rx_data, rx_done_sig, frame_err, rx_busy
  );
endinterface

// File: rtl/rx_control_module_bps.sv
// rtl/rx_control_module_bps.sv - baud counter giving half-bit and full-bit ticks
module rx_bps_module #(
  parameter int BPS_CNT = 434,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic half_tick,
  output logic full_tick
);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (run)
      cnt <= cnt + CNT_W'(1);
  end

  // Ticks decode the count alone so the FSM can consume them without a comb loop through run.
  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);
endmodule

// File: rtl/rx_control_module.sv
// rtl/rx_control_module.sv - 8N1 UART receive controller with framing error report
module rx_control_module
  import rx_control_module_pkg::*;
#(
  parameter int BPS_CNT = BPS_115200,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  rx_control_module_if.slave  bus
);
  logic       rx_meta, rxs;
  rx_state_e  state, state_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic [7:0] shift, shift_nxt;
  logic [7:0] data_q, data_nxt;
  logic       done_q, done_nxt;
  logic       ferr_q, ferr_nxt;
  logic       clear, run, half_tick, full_tick;

  rx_bps_module #(.BPS_CNT(BPS_CNT), .CNT_W(CNT_W)) u_bps (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .run       (run),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx_pin;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      done_q  <= done_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = data_q;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    clear       = 1'b0;
    run         = 1'b0;
    if (state != S_IDLE && !bus.rx_en) begin
      state_nxt = S_IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.rx_en && bus.h2l_sig) begin
            clear     = 1'b1;
            state_nxt = S_START;
          end
        end
        S_START: begin
          run = 1'b1;
          if (half_tick) begin
            clear = 1'b1;
            if (!rxs) begin
              bit_idx_nxt = 3'd0;
              state_nxt   = S_DATA;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_DATA: begin
          run = 1'b1;
          if (full_tick) begin
            clear     = 1'b1;
            shift_nxt = {rxs, shift[7:1]};
            if (bit_idx == 3'd7)
              state_nxt = S_STOP;
            else
              bit_idx_nxt = bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          run = 1'b1;
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (full_tick) begin
            clear     = 1'b1;
            state_nxt = S_IDLE;
            if (rxs) begin
              data_nxt = shift;
              done_nxt = 1'b1;
            end else begin
              ferr_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_done_sig = done_q;
  assign bus.frame_err   = ferr_q;
  assign bus.rx_busy     = (state != S_IDLE);
endmodule

// File: tb/tb_rx_control_module.sv
// tb/tb_rx_control_module.sv - scoreboard bench for rx_control_module
module tb_rx_control_module;
  localparam int BPS     = 16;
  localparam int LAT     = BPS / 2 + 9 * BPS + 1;
  localparam int FRAME   = 10 * BPS;
  localparam int DET_DLY = 7;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;

  rx_control_module_if bus();

  rx_control_module #(.BPS_CNT(BPS), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        check("pulse_missing", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.rx_done_sig || bus.frame_err) begin
        check("done_err_exclusive", {31'd0, bus.rx_done_sig & bus.frame_err}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, bus.rx_done_sig, bus.frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", {31'd0, bus.frame_err}, {31'd0, e.is_err});
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.rx_pin  = 1'b1;
      bus.h2l_sig = 1'b0;
    end
  endtask

  // Serialise one frame; the detector is modelled as an h2l_sig pulse DET_DLY cycles after the start fall.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit en,
                            input int abort_at, input int reset_at);
    bit expect_out;
    expect_out = en && abort_at < 0 && reset_at < 0;
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      if (i < BPS)            bus.rx_pin = 1'b0;
      else if (i < 9 * BPS)   bus.rx_pin = d[(i - BPS) / BPS];
      else                    bus.rx_pin = stop;
      bus.h2l_sig = (i == DET_DLY);
      bus.rx_en   = en && !(abort_at >= 0 && i >= abort_at);
      rst_n       = !(i == reset_at);
      if (i == DET_DLY && expect_out) begin
        exp_q.push_back('{is_err: !stop, data: stop ? d : model_data, cyc: cyc + LAT});
        if (stop) model_data = d;
      end
      if (i == reset_at) model_data = 8'h00;
      if (abort_at >= 0 && i == abort_at + 1)
        check("busy_after_abort", {31'd0, bus.rx_busy}, 0);
      if (reset_at >= 0 && i == reset_at + 1)
        check("outputs_after_reset",
              {21'd0, bus.rx_data, bus.rx_done_sig, bus.frame_err, bus.rx_busy}, 0);
    end
    bus.rx_en = 1'b1;
  endtask

  task automatic glitch();
    for (int i = 0; i < 3 * BPS; i++) begin
      @(posedge clk); #1;
      bus.rx_pin  = !(i < 5);
      bus.h2l_sig = (i == DET_DLY);
      if (i == BPS - 1) check("glitch_busy_before_half", {31'd0, bus.rx_busy}, 1);
      if (i == BPS)     check("glitch_idle_at_half", {31'd0, bus.rx_busy}, 0);
    end
  endtask

  task automatic check_held(input string name);
    idle(3);
    check(name, {24'd0, bus.rx_data}, {24'd0, model_data});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.rx_pin  = 1'b1;
    bus.h2l_sig = 1'b0;
    bus.rx_en   = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {21'd0, bus.rx_data, bus.rx_done_sig, bus.frame_err, bus.rx_busy}, 0);
    rst_n = 1'b1;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    check_held("t1_rx_data_a5");
    glitch();
    check_held("t2_glitch_data_held");
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1);
    check_held("t3_ferr_data_held");
    send_frame(8'h00, 1'b1, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b1, -1, -1);
    check_held("t4_back_to_back_ff");
    send_frame(8'h77, 1'b1, 1'b1, 4 * BPS + 6, -1);
    check_held("t5_abort_data_held");
    send_frame(8'h5A, 1'b1, 1'b1, -1, -1);
    check_held("t5_after_abort_5a");
    send_frame(8'hE7, 1'b1, 1'b1, -1, 6 * BPS + 4);
    check_held("t6_after_reset_zero");
    send_frame(8'h81, 1'b1, 1'b1, -1, -1);
    check_held("t6_after_reset_81");

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        glitch();
      end else begin
        send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 7) != 0,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(BPS + 4, 8 * BPS)) : -1, -1);
      end
      idle($urandom_range(0, 12));
    end

    idle(2 * BPS);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_rx_data", {24'd0, bus.rx_data}, {24'd0, model_data});
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
